shift_seq_32: RTL and testbench

- Multi-cycle 32-bit shifter that shifts one bit position per clock.
- Covers the directions the combinational right-logical shifter does not: logical shift left (SLL) and arithmetic shift right (SRA).
- Reports the last bit shifted out on co, the same way the add-with-carry element reports carry-out.
- Sits beside the combinational ALU elements; the multi-cycle datapath controller drives it through a start/busy/done handshake.

---
 rtl/shift_seq_32.sv | 132 +++++++++++++
 tb/tb_shift_seq_32.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_seq_32.sv
// ---------------------------------------------------------------------------
// shift_seq_32
//
// Multi-cycle shifter that moves the operand one bit position per clock.
// It covers logical shift left (SLL, zero fill at the LSB) and arithmetic
// shift right (SRA, sign fill at the MSB). The last bit shifted out is
// reported on co, in the same way the add-with-carry element reports its
// carry-out. The datapath controller drives it with a start/busy/done
// handshake.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   synchronous active-low reset
//   start  in   request, sampled only while busy=0
//   a      in   operand, captured on an accepted start
//   shift  in   shift amount 0..2**SHW-1, captured on an accepted start
//   dir    in   0 = SLL, 1 = SRA, captured on an accepted start
//   busy   out  high from the cycle after acceptance through the done cycle
//   done   out  one-cycle pulse; result and co are valid in this cycle
//   result out  shifted value, held until the next completion
//   co     out  last bit shifted out (0 when shift=0), held with result
// ---------------------------------------------------------------------------
module shift_seq_32 #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [SHW-1:0]   shift,
    input  logic             dir,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             co
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] wreg;
    logic [WIDTH-1:0] wreg_nxt;
    logic [SHW-1:0]   cnt;
    logic [SHW-1:0]   cnt_nxt;
    logic             op;
    logic             op_nxt;
    logic             shco;
    logic             shco_nxt;

    // Next-state and datapath logic. IDLE loads a fresh operation when start
    // is seen; a zero shift amount goes straight to DONE so the caller still
    // gets exactly one done pulse. SHIFT moves the working register by one
    // position per cycle and keeps the bit that fell off in the shadow carry,
    // so that after the final step the shadow carry holds the last bit out.
    // DONE always returns to IDLE, which is why start during DONE is ignored.
    always_comb begin
        state_nxt = state;
        wreg_nxt  = wreg;
        cnt_nxt   = cnt;
        op_nxt    = op;
        shco_nxt  = shco;
        case (state)
            IDLE: begin
                if (start) begin
                    wreg_nxt  = a;
                    cnt_nxt   = shift;
                    op_nxt    = dir;
                    shco_nxt  = 1'b0;
                    state_nxt = (shift == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (op) begin
                    shco_nxt = wreg[0];
                    wreg_nxt = {wreg[WIDTH-1], wreg[WIDTH-1:1]};
                end else begin
                    shco_nxt = wreg[WIDTH-1];
                    wreg_nxt = {wreg[WIDTH-2:0], 1'b0};
                end
                cnt_nxt = cnt - 1'b1;
                if (cnt == SHW'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset clears everything, including any
    // operation in flight, and wins over a simultaneous start. result and co
    // are loaded only on the edge that enters DONE, using the value the
    // working register is taking on that same edge, so partial shift values
    // never appear on result. busy and done are registered from the next
    // state so the outputs line up exactly with the SHIFT/DONE states.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            wreg   <= '0;
            cnt    <= '0;
            op     <= 1'b0;
            shco   <= 1'b0;
            result <= '0;
            co     <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state <= state_nxt;
            wreg  <= wreg_nxt;
            cnt   <= cnt_nxt;
            op    <= op_nxt;
            shco  <= shco_nxt;
            busy  <= (state_nxt != IDLE);
            done  <= (state_nxt == DONE);
            if (state_nxt == DONE) begin
                result <= wreg_nxt;
                co     <= shco_nxt;
            end
        end
    end

endmodule

// File: tb/tb_shift_seq_32.sv
// ---------------------------------------------------------------------------
// tb_shift_seq_32
//
// Self-checking bench for shift_seq_32. A table of directed vectors with
// hand-computed results is issued back to back; hand-written sequences cover
// reset behaviour, start while busy, and reset in the middle of a shift.
// ---------------------------------------------------------------------------
module tb_shift_seq_32;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] a;
    logic [4:0]  shift;
    logic        dir;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        co;

    int total;
    int bad;

    typedef struct {
        logic [31:0] a;
        logic [4:0]  sh;
        logic        dir;
        logic [31:0] expResult;
        logic        expCo;
    } vecT;

    vecT vecs[11];

    shift_seq_32 #(.WIDTH(32), .SHW(5)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .shift  (shift),
        .dir    (dir),
        .busy   (busy),
        .done   (done),
        .result (result),
        .co     (co)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison: counts it, and reports a failure with both values.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    // Issues one request in an IDLE cycle, then waits (bounded) for done.
    // lat is the cycle of the done pulse counting the cycle right after the
    // accepting edge as 1 (0 means it never came). busyCycles counts cycles
    // with busy high up to and including done; held reports whether result
    // stayed at its previous value until done.
    task automatic applyStimulus(input logic [31:0] av, input logic [4:0] sv, input logic dv,
                                 output int lat, output int busyCycles, output logic held);
        logic [31:0] prev;
        prev = result;
        held = 1'b1;
        lat = 0;
        busyCycles = 0;
        @(negedge clk);
        a = av;
        shift = sv;
        dir = dv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (busy) busyCycles++;
            if (done) begin
                lat = c;
                break;
            end
            if (result !== prev) held = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int lat;
        int bc;
        int doneCount;
        logic held;

        total = 0;
        bad = 0;

        vecs[0]  = '{32'hA5A5A5A5, 5'd2,  1'b0, 32'h96969694, 1'b0};
        vecs[1]  = '{32'h96969694, 5'd3,  1'b0, 32'hB4B4B4A0, 1'b0};
        vecs[2]  = '{32'hA5A5A5A5, 5'd3,  1'b0, 32'h2D2D2D28, 1'b1};
        vecs[3]  = '{32'h80000001, 5'd1,  1'b1, 32'hC0000000, 1'b1};
        vecs[4]  = '{32'hF1111110, 5'd4,  1'b1, 32'hFF111111, 1'b0};
        vecs[5]  = '{32'h12345678, 5'd0,  1'b0, 32'h12345678, 1'b0};
        vecs[6]  = '{32'h12345678, 5'd0,  1'b1, 32'h12345678, 1'b0};
        vecs[7]  = '{32'h80000000, 5'd31, 1'b1, 32'hFFFFFFFF, 1'b0};
        vecs[8]  = '{32'h7FFFFFFF, 5'd31, 1'b1, 32'h00000000, 1'b1};
        vecs[9]  = '{32'hFFFFFFFF, 5'd31, 1'b0, 32'h80000000, 1'b1};
        vecs[10] = '{32'h00000001, 5'd1,  1'b0, 32'h00000002, 1'b0};

        // Reset held for two cycles with start high: nothing may begin.
        rst_n = 1'b0;
        start = 1'b1;
        a = 32'hDEADBEEF;
        shift = 5'd3;
        dir = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_result", result, 32'h0);
        checkOutput("rst_co", 32'(co), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rst_no_op_busy", 32'(busy), 32'd0);

        // Table-driven vectors, issued back to back.
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].a, vecs[i].sh, vecs[i].dir, lat, bc, held);
            checkOutput($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].sh) + 32'd1);
            checkOutput($sformatf("v%0d_busy_cycles", i), 32'(bc), 32'(vecs[i].sh) + 32'd1);
            checkOutput($sformatf("v%0d_result_held", i), 32'(held), 32'd1);
            checkOutput($sformatf("v%0d_result", i), result, vecs[i].expResult);
            checkOutput($sformatf("v%0d_co", i), 32'(co), 32'(vecs[i].expCo));
            @(posedge clk);
            #1;
            checkOutput($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
            checkOutput($sformatf("v%0d_idle", i), 32'(busy), 32'd0);
            checkOutput($sformatf("v%0d_result_kept", i), result, vecs[i].expResult);
        end

        // Start while busy: a second request mid-shift and start held in the
        // done cycle must both be ignored.
        lat = 0;
        doneCount = 0;
        @(negedge clk);
        a = 32'h00000001;
        shift = 5'd31;
        dir = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 1; c <= 45; c++) begin
            start = (c == 5) || done;
            if (c == 5) begin
                a = 32'hFFFFFFFF;
                shift = 5'd1;
            end
            if (done) begin
                doneCount++;
                lat = c;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        checkOutput("busyprot_done_count", 32'(doneCount), 32'd1);
        checkOutput("busyprot_latency", 32'(lat), 32'd32);
        checkOutput("busyprot_result", result, 32'h80000000);
        checkOutput("busyprot_co", 32'(co), 32'd0);
        checkOutput("busyprot_idle", 32'(busy), 32'd0);

        // Reset in the middle of a shift: abort, clear, no done pulse.
        doneCount = 0;
        @(negedge clk);
        a = 32'hA5A5A5A5;
        shift = 5'd20;
        dir = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 1; c < 6; c++) begin
            if (done) doneCount++;
            @(posedge clk);
            #1;
        end
        checkOutput("midrst_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_done", 32'(done), 32'd0);
        checkOutput("midrst_result", result, 32'h0);
        checkOutput("midrst_co", 32'(co), 32'd0);
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            if (done) doneCount++;
        end
        checkOutput("midrst_no_done", 32'(doneCount), 32'd0);
        checkOutput("midrst_result_kept", result, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
